// File: rtl/skinny_sbox_layer_seq.sv
// Byte-serial sequencer feeding a shared masked Skinny S-box with one two-share byte at a time.
// Optional precharge state between bytes: define SKINNY_SBOX_SEQ_CLEAR_EN.
module skinny_sbox_layer_seq #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned NBYTES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   si1,
  input  logic [8*NBYTES-1:0]   si0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   so1,
  output logic [8*NBYTES-1:0]   so0,
  input  logic [7:0]            rnd,
  output logic                  rnd_ack,
  output logic [7:0]            sb_si1,
  output logic [7:0]            sb_si0,
  output logic [7:0]            sb_r,
  input  logic [7:0]            sb_bo1,
  input  logic [7:0]            sb_bo0,
  output logic                  busy
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CW = 4;

`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_HOLD, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HOLD, S_DONE} state_t;
`endif

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    ws1_q, ws0_q;
  logic [W-1:0]    so1_q, so0_q;
  logic [7:0]      sb_si1_q, sb_si0_q, sb_r_q;
  logic            in_ready_q, out_valid_q, busy_q, rnd_ack_q;
  logic [7:0]      cur_b1, cur_b0;
  logic            last_byte, last_cnt;

  // Shares are selected independently; nothing here ever mixes share 1 with share 0.
  always_comb begin
    cur_b1    = ws1_q[{idx_q, 3'b000} +: 8];
    cur_b0    = ws0_q[{idx_q, 3'b000} +: 8];
    last_byte = (idx_q == IW'(NBYTES - 1));
    last_cnt  = (cnt_q == CW'(HOLD_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      ws1_q       <= '0;
      ws0_q       <= '0;
      so1_q       <= '0;
      so0_q       <= '0;
      sb_si1_q    <= '0;
      sb_si0_q    <= '0;
      sb_r_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_ack_q   <= 1'b0;
    end else begin
      rnd_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ws1_q      <= si1;
            ws0_q      <= si0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
            state_q    <= S_CLEAR;
`else
            state_q    <= S_SETUP;
            rnd_ack_q  <= 1'b1;
`endif
          end
        end
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
        S_CLEAR: begin
          sb_si1_q  <= '0;
          sb_si0_q  <= '0;
          sb_r_q    <= '0;
          rnd_ack_q <= 1'b1;
          state_q   <= S_SETUP;
        end
`endif
        S_SETUP: begin
          sb_si1_q <= cur_b1;
          sb_si0_q <= cur_b0;
          sb_r_q   <= rnd;
          cnt_q    <= '0;
          state_q  <= S_HOLD;
        end
        S_HOLD: begin
          if (last_cnt) begin
            so1_q[{idx_q, 3'b000} +: 8] <= sb_bo1;
            so0_q[{idx_q, 3'b000} +: 8] <= sb_bo0;
            if (last_byte) begin
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              idx_q <= idx_q + IW'(1);
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
              state_q   <= S_CLEAR;
`else
              state_q   <= S_SETUP;
              rnd_ack_q <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
            ws1_q <= '0;
            ws0_q <= '0;
            so1_q <= '0;
            so0_q <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rnd_ack   = rnd_ack_q;
  assign so1       = so1_q;
  assign so0       = so0_q;
  assign sb_si1    = sb_si1_q;
  assign sb_si0    = sb_si0_q;
  assign sb_r      = sb_r_q;

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Directed bench for skinny_sbox_layer_seq with a behavioural two-share S-box stand-in.
// Honours SKINNY_SBOX_SEQ_CLEAR_EN and a HOLD_CYCLES override.
module tb_skinny_sbox_layer_seq;
  parameter int unsigned HOLD_CYCLES = 8;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned W = 8 * NBYTES;
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
  localparam int unsigned CLR = 1;
`else
  localparam int unsigned CLR = 0;
`endif
  localparam int unsigned P   = 1 + HOLD_CYCLES + CLR;
  localparam int unsigned LAT = NBYTES * P;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, rnd_ack, busy;
  logic [W-1:0] si1, si0, so1, so0;
  logic [7:0] rnd, sb_si1, sb_si0, sb_r, sb_bo1, sb_bo0;
  int checks = 0;
  int fails  = 0;

  skinny_sbox_layer_seq #(.HOLD_CYCLES(HOLD_CYCLES), .NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .si1(si1), .si0(si0), .out_valid(out_valid), .out_ready(out_ready),
    .so1(so1), .so0(so0), .rnd(rnd), .rnd_ack(rnd_ack),
    .sb_si1(sb_si1), .sb_si0(sb_si0), .sb_r(sb_r),
    .sb_bo1(sb_bo1), .sb_bo0(sb_bo0), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the two unshared inputs the bench uses are exact Skinny values; others are arbitrary.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    case (x)
      8'h00:   sbox = 8'h65;
      8'hFF:   sbox = 8'hFF;
      default: sbox = x ^ 8'hA5;
    endcase
  endfunction

  assign sb_bo0 = sb_si0 ^ sb_r;
  assign sb_bo1 = sbox(sb_si1 ^ sb_si0) ^ sb_si0 ^ sb_r;

  function automatic logic [7:0] mask(input int i, input bit c);
    mask = c ? 8'h5A : (8'hC3 ^ 8'(i * 29));
  endfunction

  function automatic logic [W-1:0] exp_so0(input logic [W-1:0] s0, input bit c);
    for (int k = 0; k < NBYTES; k++) exp_so0[8*k +: 8] = s0[8*k +: 8] ^ mask(k, c);
  endfunction

  function automatic logic [W-1:0] exp_so1(input logic [W-1:0] s1, input logic [W-1:0] s0, input bit c);
    for (int k = 0; k < NBYTES; k++)
      exp_so1[8*k +: 8] = sbox(s1[8*k +: 8] ^ s0[8*k +: 8]) ^ s0[8*k +: 8] ^ mask(k, c);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept a state, then walk every cycle of the schedule checking handshakes and S-box inputs.
  // Returns early at observation stop_m (used for the mid-run reset step).
  task automatic do_run(input logic [W-1:0] s1, input logic [W-1:0] s0, input bit c,
                        input bit noisy, input int stop_m);
    int  mi   = 0;
    int  acks = 0;
    bit  adv  = 1'b0;
    int  k, ph;
    @(negedge clk);
    chk1("in_ready_idle", in_ready, 1'b1);
    si1 = s1; si0 = s0; rnd = mask(0, c); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noisy;
    si1 = ~s1; si0 = s1 ^ {NBYTES{8'h3C}};
    for (int m = 0; m < int'(LAT); m++) begin
      @(negedge clk);
      if (adv) begin mi++; rnd = mask(mi, c); adv = 1'b0; end
      if (m == stop_m) return;
      k  = m / int'(P);
      ph = m % int'(P);
      chk1("busy_run", busy, 1'b1);
      chk1("out_valid_run", out_valid, 1'b0);
      chk1("in_ready_run", in_ready, 1'b0);
      chk1("rnd_ack_sched", rnd_ack, ph == int'(CLR));
      if (rnd_ack) begin acks++; adv = 1'b1; end
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
      if (ph == 1) chk8("sb_precharge", sb_si1 | sb_si0 | sb_r, 8'h00);
`endif
      if (ph > int'(CLR)) begin
        chk8("sb_si1_hold", sb_si1, s1[8*k +: 8]);
        chk8("sb_si0_hold", sb_si0, s0[8*k +: 8]);
        chk8("sb_r_hold", sb_r, mask(k, c));
      end
    end
    @(negedge clk);
    chk1("out_valid_at_lat", out_valid, 1'b1);
    chk1("busy_done", busy, 1'b1);
    chk1("in_ready_done", in_ready, 1'b0);
    chk1("rnd_ack_done", rnd_ack, 1'b0);
    chkw("so1_result", so1, exp_so1(s1, s0, c));
    chkw("so0_result", so0, exp_so0(s0, c));
    chk_int("rnd_ack_count", acks, NBYTES);
  endtask

  task automatic check_after_release(input logic [W-1:0] e1, input logic [W-1:0] e0);
    @(negedge clk);
    chk1("in_ready_after", in_ready, 1'b1);
    chk1("out_valid_after", out_valid, 1'b0);
    chk1("busy_after", busy, 1'b0);
`ifdef SKINNY_SBOX_SEQ_CLEAR_EN
    chkw("so1_after", so1, '0);
    chkw("so0_after", so0, '0);
`else
    chkw("so1_after", so1, e1);
    chkw("so0_after", so0, e0);
`endif
  endtask

  logic [W-1:0] zs, bs0, bs1, cs0, cs1;

  initial begin
    zs  = '0;
    bs0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bs1 = bs0 ^ {W{1'b1}};
    cs0 = 128'hA1B2_C3D4_E5F6_0718_293A_4B5C_6D7E_8F90;
    cs1 = 128'h1357_9BDF_2468_ACE0_FDB9_7531_ECA8_6420;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd = 8'h00; si1 = '0; si0 = '0;
    #12;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rnd_ack", rnd_ack, 1'b0);
    chkw("rst_so1", so1, '0);
    chkw("rst_so0", so0, '0);
    chk8("rst_sb", sb_si1 | sb_si0 | sb_r, 8'h00);
    rst_n = 1'b1;

    // Unmasked zero, constant mask, out_ready already high: one-cycle DONE
    out_ready = 1'b1;
    do_run(zs, zs, 1'b1, 1'b0, -1);
    check_after_release(exp_so1(zs, zs, 1'b1), exp_so0(zs, 1'b1));
    out_ready = 1'b0;

    // Masked state with all-ones payload, in_valid left high during the run, then backpressure
    do_run(bs1, bs0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      si1 = {4{$urandom}}; si0 = {4{$urandom}};
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chkw("bp_so1", so1, exp_so1(bs1, bs0, 1'b0));
      chkw("bp_so0", so0, exp_so0(bs0, 1'b0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_after_release(exp_so1(bs1, bs0, 1'b0), exp_so0(bs0, 1'b0));
    out_ready = 1'b0;
    @(negedge clk);
    chk1("no_accept_busy", busy, 1'b0);

    // Reset during byte 7 with hold count 3
    do_run(cs1, cs0, 1'b0, 1'b0, 7 * int'(P) + int'(CLR) + 4);
    chk8("partial_so0_b0", so0[7:0], cs0[7:0] ^ mask(0, 1'b0));
    chk1("partial_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_rnd_ack", rnd_ack, 1'b0);
    chkw("mid_rst_so1", so1, '0);
    chkw("mid_rst_so0", so0, '0);
    chk8("mid_rst_sb", sb_si1 | sb_si0 | sb_r, 8'h00);
    #1;
    rst_n = 1'b1;

    // Fresh run from zero after the mid-run reset
    out_ready = 1'b1;
    do_run(zs, zs, 1'b1, 1'b0, -1);
    check_after_release(exp_so1(zs, zs, 1'b1), exp_so0(zs, 1'b1));
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/skinny_sbox_layer_seq.md
# skinny_sbox_layer_seq

Sequencer that applies the masked 8-bit Skinny S-box to a full two-share 128-bit state through a single shared, non-pipelined ISW S-box instance, one byte at a time. For each byte it presents that byte's share pair and a fresh 8-bit refresh mask to the S-box, and holds all of them stable for the S-box's full settle window. It then captures the output share pair into the result state. It sits between the round controller (valid/ready on both sides) and the S-box instance, whose ports it drives directly.

## Interface
- HOLD_CYCLES, 8, cycles each byte's inputs and mask are held stable at the S-box; legal range 4..15
- NBYTES, 16, bytes per state; state width is 8*NBYTES
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  sequencer idle and able to accept a state
- si1, si0  in  8*NBYTES  input state shares 1 and 0
- out_valid  out  1  result state valid
- out_ready  in  1  consumer accepts result
- so1, so0  out  8*NBYTES  result state shares 1 and 0 (registered)
- rnd  in  8  fresh randomness, always valid (PRNG-fed)
- rnd_ack  out  1  one-cycle pulse: rnd consumed this cycle, PRNG advances
- sb_si1, sb_si0  out  8  byte shares to the S-box (registered)
- sb_r  out  8  refresh mask to the S-box (registered)
- sb_bo1, sb_bo0  in  8  S-box output shares
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SETUP, HOLD, DONE (plus CLEAR when configured).
- Counters:
  - idx: 0..NBYTES-1, byte index.
  - cnt: 0..HOLD_CYCLES-1, hold counter.
- Byte k is bits [8k+7:8k]. Bytes are processed in order k=0 first.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch si1/si0 into the working state, set idx=0, go to SETUP.
- SETUP (1 cycle):
  - rnd_ack=1.
  - At the edge: sb_si1/sb_si0 <= byte idx of the working state, sb_r <= rnd, cnt <= 0, go to HOLD.
- HOLD:
  - sb_si1, sb_si0 and sb_r do not change.
  - cnt increments each cycle.
  - On the cycle with cnt==HOLD_CYCLES-1, at the edge: so1/so0 byte idx <= sb_bo1/sb_bo0.
  - Then, if idx==NBYTES-1, go to DONE; else idx <= idx+1 and go to SETUP (CLEAR when configured).
- DONE:
  - out_valid=1, so1/so0 stable.
  - On out_ready, go to IDLE.
  - out_ready is ignored in all other states.
- in_valid is ignored outside IDLE.
- si1/si0 may change after acceptance.
- A new state can be accepted only after return to IDLE. There is no overlap with DONE.
- Mask freshness:
  - Exactly one rnd_ack per byte.
  - sb_r is never reused across bytes.
- Shares are never combined inside this block: no XOR of share 1 with share 0 on any path.

## Timing
- Reset (async, any state, including mid-byte):
  - state=IDLE, idx=0, cnt=0.
  - in_ready=1, out_valid=0, busy=0, rnd_ack=0.
  - so1, so0, sb_si1, sb_si0 and sb_r all 0.
  - The working state is cleared to 0.
- Per-byte cost: 1+HOLD_CYCLES cycles; default 9.
- Latency from the accepting edge to out_valid=1: NBYTES*(1+HOLD_CYCLES) cycles; default 144.
- out_valid=1 with out_ready=1 in the same cycle: a one-cycle DONE, in_ready=1 on the next cycle.
- out_ready held low: DONE persists indefinitely, with outputs frozen.
- Counters never wrap. idx stops at NBYTES-1 and cnt resets in SETUP.

## Configuration
- SKINNY_SBOX_SEQ_CLEAR_EN defined:
  - Adds a CLEAR state before every SETUP, including byte 0.
  - CLEAR lasts 1 cycle and forces sb_si1=sb_si0=sb_r=0 at its edge. This precharges the S-box inputs so consecutive bytes' shares never transition directly into each other.
  - Per-byte cost becomes 2+HOLD_CYCLES; default latency 160.
  - On leaving DONE, the working state and so1/so0 are cleared to 0.
- SKINNY_SBOX_SEQ_CLEAR_EN not defined:
  - No CLEAR state.
  - The working state and so1/so0 keep the last values until overwritten.

## Test plan
- Unmasked zero:
  - Stimulus: si1=si0=0, rnd=0x5A constant, real S-box attached.
  - Required: out_valid rises exactly 144 cycles after acceptance (160 with CLEAR), and so1^so0 = 0x65 in every byte.
- Masked random state:
  - Stimulus: random si0, si1=si0^P with P=0xFF..FF, random rnd each cycle.
  - Required: so1^so0 = 0xFF in every byte, and 16 rnd_ack pulses are counted.
- Stability checker:
  - Stimulus: a normal run.
  - Required: sb_si1, sb_si0 and sb_r are constant throughout every HOLD window of 8 cycles, and each sb_r equals the rnd sampled in the preceding SETUP.
- Backpressure:
  - Stimulus: hold out_ready=0 for 50 cycles after out_valid, and toggle in_valid meanwhile.
  - Required: so1/so0 unchanged, in_ready=0 until the cycle after out_ready=1, and no new acceptance.
- Reset mid-run:
  - Stimulus: drop rst_n during byte 7, HOLD cnt=3.
  - Required: all outputs go to 0 immediately and in_ready=1; a following run from zero state gives 0x65 in every byte.
- HOLD_CYCLES=4 build:
  - Required: latency 80 cycles, results identical to the default build.
